// File: rtl/game_pkg.sv
// Shared types, constants and helpers for the multi-object mover.
// Declarations only; no latency.
// No flow control; consumers are free-running pixel-rate logic.
package game_pkg;

    localparam int COORD_W = 10;
    // One extra bit so position +/- speed comparisons never wrap.
    localparam int CALC_W  = COORD_W + 1;

    typedef enum logic [1:0] {
        MODE_BTN   = 2'd0,
        MODE_ACCEL = 2'd1,
        MODE_AUTO  = 2'd2
    } mode_t;

    typedef logic [0:0] fsm_t;
    localparam fsm_t IDLE   = 1'b0;
    localparam fsm_t UPDATE = 1'b1;

    // Per-object state; neg_* set means moving toward decreasing coordinate.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               neg_h;
        logic               neg_v;
    } obj_t;

    // Mode-cycle order used by the mode button.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_BTN:   return MODE_ACCEL;
            MODE_ACCEL: return MODE_AUTO;
            default:    return MODE_BTN;
        endcase
    endfunction

endpackage

// File: rtl/obj_pos_step.sv
// One-axis position step: moves pos by speed in dir, clamps to [lo, hi] and flips dir on clamp.
// Purely combinational, zero latency.
// No flow control; result is consumed by the caller in the same cycle.
module obj_pos_step
    import game_pkg::*;
#(
    parameter int SPEED_W = 4
) (
    input  logic [COORD_W-1:0] pos,
    input  logic               dir_neg,
    input  logic               move,
    input  logic [SPEED_W-1:0] speed,
    input  logic [COORD_W-1:0] lo,
    input  logic [COORD_W-1:0] hi,
    output logic [COORD_W-1:0] new_pos,
    output logic               new_dir_neg
);

    logic [CALC_W-1:0] pos_w;
    logic [CALC_W-1:0] spd_w;
    logic [CALC_W-1:0] up_w;
    logic [CALC_W-1:0] dn_w;
    logic [CALC_W-1:0] lo_lim;
    logic              clamped;

    // Step in the widened domain; a step that would pass an edge lands on it and reverses direction.
    always_comb begin
        pos_w       = {1'b0, pos};
        spd_w       = CALC_W'(speed);
        up_w        = pos_w + spd_w;
        dn_w        = pos_w - spd_w;
        lo_lim      = {1'b0, lo} + spd_w;
        new_pos     = pos;
        clamped     = 1'b0;
        if (move) begin
            if (dir_neg) begin
                if (pos_w < lo_lim) begin
                    new_pos = lo;
                    clamped = 1'b1;
                end else begin
                    new_pos = dn_w[COORD_W-1:0];
                end
            end else begin
                if (up_w > {1'b0, hi}) begin
                    new_pos = hi;
                    clamped = 1'b1;
                end else begin
                    new_pos = up_w[COORD_W-1:0];
                end
            end
        end
        new_dir_neg = dir_neg ^ clamped;
    end

endmodule

// File: rtl/multi_object_mover.sv
// Game-object engine: N_OBJ rectangles, one user-steered, rest bounce; per-pixel draw flags. Optional macro COLLISION_EN.
// Draw flags 1 cycle after h/v; positions update N_OBJ cycles after the registered frame-end tick.
// No backpressure: free-running at pixel rate; the update walk must fit inside vertical blanking.
module multi_object_mover
    import game_pkg::*;
#(
    parameter int H_RES             = 640,
    parameter int V_RES             = 480,
    parameter int N_OBJ             = 4,
    parameter int OBJ_W             = 4,
    parameter int OBJ_H             = 10,
    parameter int FRAMES_PER_ACTION = 2,
    parameter int SPEED_W           = 4,
    parameter int ACCEL_DZ          = 2
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic [9:0]         h_coord,
    input  logic [9:0]         v_coord,
    input  logic               button_u,
    input  logic               button_d,
    input  logic               button_l,
    input  logic               button_r,
    input  logic               button_c,
    input  logic               sel_next,
    input  logic [7:0]         accel_x,
    input  logic [7:0]         accel_y,
    input  logic [SPEED_W-1:0] speed,
    output logic [N_OBJ-1:0]   obj_draw,
    output logic [2:0]         obj_hit_id,
    output logic [2:0]         sel_idx,
    output logic [1:0]         mode,
    output logic               collision
);

    localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
    localparam int FC_W  = (FRAMES_PER_ACTION > 1) ? $clog2(FRAMES_PER_ACTION) : 1;

    localparam logic [COORD_W-1:0] H_MAX = COORD_W'(H_RES - OBJ_W);
    localparam logic [COORD_W-1:0] V_MAX = COORD_W'(V_RES - OBJ_H);
    localparam logic [CALC_W-1:0]  W_M1  = CALC_W'(OBJ_W - 1);
    localparam logic [CALC_W-1:0]  H_M1  = CALC_W'(OBJ_H - 1);

    localparam logic signed [7:0] DZ_P = 8'(ACCEL_DZ);
    localparam logic signed [7:0] DZ_N = 8'(-ACCEL_DZ);

    // Power-up placement: spaced columns, vertically centred, direction from index bits.
    function automatic obj_t init_obj(input int i);
        obj_t o;
        o.x     = COORD_W'(16 + 32 * i);
        o.y     = COORD_W'(V_RES / 2 - OBJ_H / 2);
        o.neg_h = i[0];
        o.neg_v = i[1];
        return o;
    endfunction

    obj_t               objs [N_OBJ];
    obj_t               cur;
    obj_t               nxt_obj;

    fsm_t               state;
    logic [IDX_W-1:0]   upd_idx;
    logic               frame_end_q;
    logic [FC_W-1:0]    frame_cnt;
    logic               tick;

    mode_t              mode_q;
    logic [IDX_W-1:0]   sel_q;
    logic               btn_c_q;
    logic               sel_next_q;
    logic               c_rise;
    logic               s_rise;

    mode_t              lat_mode;
    logic [IDX_W-1:0]   lat_sel;
    logic               lat_u, lat_d, lat_l, lat_r;
    logic signed [7:0]  lat_ax;
    logic signed [7:0]  lat_ay;
    logic [SPEED_W-1:0] lat_speed;

    logic               is_sel;
    logic               user_ctrl;
    logic               h_move, h_neg, v_move, v_neg;
    logic [COORD_W-1:0] nx, ny;
    logic               ndh, ndv;
    logic               coll_hit;

    logic [N_OBJ-1:0]   hit_vec;
    logic [N_OBJ-1:0]   obj_draw_q;
    logic               collision_q;

    assign tick   = frame_end_q && (frame_cnt == '0);
    assign c_rise = button_c && !btn_c_q;
    assign s_rise = sel_next && !sel_next_q;

    assign cur       = objs[upd_idx];
    assign is_sel    = (upd_idx == lat_sel);
    assign user_ctrl = is_sel && (lat_mode != MODE_AUTO);

    // Direction request for the object being updated: user input for the steered one, stored dirs otherwise.
    always_comb begin
        h_move = 1'b1;
        h_neg  = cur.neg_h;
        v_move = 1'b1;
        v_neg  = cur.neg_v;
        if (user_ctrl) begin
            if (lat_mode == MODE_BTN) begin
                h_move = lat_l || lat_r;
                h_neg  = lat_l;
                v_move = lat_u || lat_d;
                v_neg  = lat_u;
            end else begin
                h_move = (lat_ay > DZ_P) || (lat_ay < DZ_N);
                h_neg  = (lat_ay > DZ_P);
                v_move = (lat_ax < DZ_N) || (lat_ax > DZ_P);
                v_neg  = (lat_ax < DZ_N);
            end
        end
    end

    obj_pos_step #(.SPEED_W(SPEED_W)) u_step_h (
        .pos         (cur.x),
        .dir_neg     (h_neg),
        .move        (h_move),
        .speed       (lat_speed),
        .lo          ('0),
        .hi          (H_MAX),
        .new_pos     (nx),
        .new_dir_neg (ndh)
    );

    obj_pos_step #(.SPEED_W(SPEED_W)) u_step_v (
        .pos         (cur.y),
        .dir_neg     (v_neg),
        .move        (v_move),
        .speed       (lat_speed),
        .lo          ('0),
        .hi          (V_MAX),
        .new_pos     (ny),
        .new_dir_neg (ndv)
    );

`ifdef COLLISION_EN
    logic [CALC_W-1:0] sx, sy, nxw, nyw;

    // AABB test of the freshly stepped object against the steered one's stored position.
    // Objects are walked in index order, so the steered object is already post-move for higher indices.
    always_comb begin
        sx       = {1'b0, objs[lat_sel].x};
        sy       = {1'b0, objs[lat_sel].y};
        nxw      = {1'b0, nx};
        nyw      = {1'b0, ny};
        coll_hit = !is_sel
                   && (nxw <= sx + W_M1) && (sx <= nxw + W_M1)
                   && (nyw <= sy + H_M1) && (sy <= nyw + H_M1);
    end
`else
    assign coll_hit = 1'b0;
`endif

    // Assemble the write-back value; steered objects keep their stored dirs, collisions flip both dirs.
    always_comb begin
        nxt_obj.x     = nx;
        nxt_obj.y     = ny;
        nxt_obj.neg_h = user_ctrl ? cur.neg_h : (ndh ^ coll_hit);
        nxt_obj.neg_v = user_ctrl ? cur.neg_v : (ndv ^ coll_hit);
    end

    // Frame-end detect and action-tick divider.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            frame_end_q <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_end_q <= (h_coord == 10'(H_RES - 1)) && (v_coord == 10'(V_RES - 1));
            if (frame_end_q) begin
                frame_cnt <= (frame_cnt == FC_W'(FRAMES_PER_ACTION - 1)) ? '0 : frame_cnt + 1'b1;
            end
        end
    end

    // Button edge detection driving mode cycling and object selection.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            btn_c_q    <= 1'b0;
            sel_next_q <= 1'b0;
            mode_q     <= MODE_BTN;
            sel_q      <= '0;
        end else begin
            btn_c_q    <= button_c;
            sel_next_q <= sel_next;
            if (c_rise) mode_q <= next_mode(mode_q);
            if (s_rise) sel_q <= (sel_q == IDX_W'(N_OBJ - 1)) ? '0 : sel_q + 1'b1;
        end
    end

    // Update walk: latch controls on tick, then rewrite one object per cycle.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state     <= IDLE;
            upd_idx   <= '0;
            lat_mode  <= MODE_BTN;
            lat_sel   <= '0;
            lat_u     <= 1'b0;
            lat_d     <= 1'b0;
            lat_l     <= 1'b0;
            lat_r     <= 1'b0;
            lat_ax    <= '0;
            lat_ay    <= '0;
            lat_speed <= '0;
            for (int i = 0; i < N_OBJ; i++) objs[i] <= init_obj(i);
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        lat_mode  <= mode_q;
                        lat_sel   <= sel_q;
                        lat_u     <= button_u;
                        lat_d     <= button_d;
                        lat_l     <= button_l;
                        lat_r     <= button_r;
                        lat_ax    <= accel_x;
                        lat_ay    <= accel_y;
                        lat_speed <= speed;
                        upd_idx   <= '0;
                        state     <= UPDATE;
                    end
                end
                UPDATE: begin
                    objs[upd_idx] <= nxt_obj;
                    if (upd_idx == IDX_W'(N_OBJ - 1)) begin
                        state <= IDLE;
                    end else begin
                        upd_idx <= upd_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky collision flag; a mode-button edge clears it, a new overlap in the same cycle wins.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            collision_q <= 1'b0;
        end else begin
            if (c_rise) collision_q <= 1'b0;
            if (state == UPDATE && coll_hit) collision_q <= 1'b1;
        end
    end

    // Per-object rectangle hit for the current pixel.
    always_comb begin
        for (int i = 0; i < N_OBJ; i++) begin
            hit_vec[i] = ({1'b0, h_coord} >= {1'b0, objs[i].x})
                      && ({1'b0, h_coord} <= {1'b0, objs[i].x} + W_M1)
                      && ({1'b0, v_coord} >= {1'b0, objs[i].y})
                      && ({1'b0, v_coord} <= {1'b0, objs[i].y} + H_M1);
        end
    end

    // Register draw flags: one pixel of latency to the RGB mux.
    always_ff @(posedge pixel_clk) begin
        if (rst) obj_draw_q <= '0;
        else     obj_draw_q <= hit_vec;
    end

    // Lowest set draw flag wins the hit id.
    always_comb begin
        obj_hit_id = 3'd0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (obj_draw_q[i]) obj_hit_id = 3'(i);
        end
    end

    assign obj_draw  = obj_draw_q;
    assign sel_idx   = 3'(sel_q);
    assign mode      = mode_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_multi_object_mover.sv
// Directed bench for multi_object_mover: reset, draw latency, button/accel/auto motion, clamps, selection, collision.
// Positions are observed only through obj_draw by probing pixels around each expected corner.
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_multi_object_mover;

    localparam int N_OBJ   = 4;
    localparam int OBJ_W   = 4;
    localparam int OBJ_H   = 10;
    localparam int SPEED_W = 4;

    logic               pixel_clk = 1'b0;
    logic               rst;
    logic [9:0]         h_coord, v_coord;
    logic               button_u, button_d, button_l, button_r, button_c, sel_next;
    logic [7:0]         accel_x, accel_y;
    logic [SPEED_W-1:0] speed;
    logic [N_OBJ-1:0]   obj_draw;
    logic [2:0]         obj_hit_id;
    logic [2:0]         sel_idx;
    logic [1:0]         mode;
    logic               collision;

    int tests = 0;
    int fails = 0;

    always #20 pixel_clk = ~pixel_clk;

    multi_object_mover #(
        .H_RES(640), .V_RES(480), .N_OBJ(N_OBJ), .OBJ_W(OBJ_W), .OBJ_H(OBJ_H),
        .FRAMES_PER_ACTION(2), .SPEED_W(SPEED_W), .ACCEL_DZ(2)
    ) dut (
        .pixel_clk  (pixel_clk),
        .rst        (rst),
        .h_coord    (h_coord),
        .v_coord    (v_coord),
        .button_u   (button_u),
        .button_d   (button_d),
        .button_l   (button_l),
        .button_r   (button_r),
        .button_c   (button_c),
        .sel_next   (sel_next),
        .accel_x    (accel_x),
        .accel_y    (accel_y),
        .speed      (speed),
        .obj_draw   (obj_draw),
        .obj_hit_id (obj_hit_id),
        .sel_idx    (sel_idx),
        .mode       (mode),
        .collision  (collision)
    );

    task automatic step();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic probe(input int i, input int x, input int y, input logic exp, input string tag);
        h_coord = 10'(x);
        v_coord = 10'(y);
        step();
        chk(tag, 32'(obj_draw[i]), 32'(exp));
    endtask

    // Pin object i to exactly (x,y): corner inside, neighbours on each side outside.
    task automatic check_pos(input int i, input int x, input int y, input string tag);
        probe(i, x, y, 1'b1, {tag, ".in"});
        if (x > 0) probe(i, x - 1, y, 1'b0, {tag, ".left"});
        if (x + OBJ_W < 1024) probe(i, x + OBJ_W, y, 1'b0, {tag, ".right"});
        if (y > 0) probe(i, x, y - 1, 1'b0, {tag, ".above"});
        if (y + OBJ_H < 1024) probe(i, x, y + OBJ_H, 1'b0, {tag, ".below"});
    endtask

    task automatic frame_pulse();
        h_coord = 10'd639;
        v_coord = 10'd479;
        step();
        h_coord = 10'd700;
        v_coord = 10'd700;
        repeat (N_OBJ + 3) step();
    endtask

    // Two frame ends per movement tick; the first one triggers the update.
    task automatic do_tick();
        frame_pulse();
        frame_pulse();
    endtask

    task automatic pulse_c();
        button_c = 1'b1;
        step();
        button_c = 1'b0;
        step();
    endtask

    task automatic pulse_sel();
        sel_next = 1'b1;
        step();
        sel_next = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        h_coord = 10'd700; v_coord = 10'd700;
        button_u = 0; button_d = 0; button_l = 0; button_r = 0;
        button_c = 0; sel_next = 0;
        accel_x = 8'h00; accel_y = 8'h00; speed = '0;

        // Reset state
        repeat (3) step();
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_sel", 32'(sel_idx), 32'd0);
        chk("rst_draw", 32'(obj_draw), 32'd0);
        chk("rst_hit_id", 32'(obj_hit_id), 32'd0);
        chk("rst_coll", 32'(collision), 32'd0);
        rst = 1'b0;
        step();
        check_pos(0, 16, 235, "rst_obj0");
        check_pos(3, 112, 235, "rst_obj3");

        // Draw flags: one-cycle latency and rectangle bounds
        h_coord = 10'd19; v_coord = 10'd236;
        #1;
        chk("draw_latency_pre", 32'(obj_draw), 32'd0);
        step();
        chk("draw_obj0", 32'(obj_draw), 32'b0001);
        chk("draw_obj0_id", 32'(obj_hit_id), 32'd0);
        probe(0, 20, 236, 1'b0, "draw_h_past");
        probe(0, 16, 245, 1'b0, "draw_v_past");
        probe(0, 16, 244, 1'b1, "draw_v_last");
        h_coord = 10'd113; v_coord = 10'd240;
        step();
        chk("draw_obj3", 32'(obj_draw), 32'b1000);
        chk("draw_obj3_id", 32'(obj_hit_id), 32'd3);

        // Button mode: left to the wall, hold, then right, then left beats right
        speed = 4'd4; button_l = 1'b1;
        repeat (4) do_tick();
        check_pos(0, 0, 235, "btn_l_reach");
        repeat (4) do_tick();
        check_pos(0, 0, 235, "btn_l_hold");
        button_l = 1'b0; button_r = 1'b1; speed = 4'd2;
        do_tick();
        check_pos(0, 2, 235, "btn_r");
        button_l = 1'b1; speed = 4'd1;
        do_tick();
        check_pos(0, 1, 235, "btn_lr");
        button_l = 1'b0; button_r = 1'b0;

        // Accelerometer mode: dead zone, steady right motion, clamp at the right wall
        pulse_c();
        chk("mode_accel", 32'(mode), 32'd1);
        speed = 4'd3; accel_y = 8'h02;
        do_tick();
        check_pos(0, 1, 235, "acc_deadzone");
        accel_y = 8'hF0;
        do_tick();
        check_pos(0, 4, 235, "acc_right");
        repeat (210) do_tick();
        check_pos(0, 634, 235, "acc_run");
        do_tick();
        check_pos(0, 636, 235, "acc_clamp");
        accel_y = 8'h10; speed = 4'd2;
        do_tick();
        check_pos(0, 634, 235, "acc_left");
        accel_y = 8'h00; accel_x = 8'hF0;
        do_tick();
        check_pos(0, 634, 233, "acc_up");
        accel_x = 8'h00;

        // Auto mode: edge bounce reverses direction on the same tick
        pulse_c();
        chk("mode_auto", 32'(mode), 32'd2);
        speed = 4'd4;
        do_tick();
        check_pos(0, 636, 237, "auto_clamp");
        do_tick();
        check_pos(0, 632, 241, "auto_reverse");
        pulse_c();
        chk("mode_wrap", 32'(mode), 32'd0);

        // Selection cycling and wrap
        pulse_sel();
        chk("sel_1", 32'(sel_idx), 32'd1);
        pulse_sel();
        pulse_sel();
        chk("sel_3", 32'(sel_idx), 32'd3);
        pulse_sel();
        chk("sel_wrap", 32'(sel_idx), 32'd0);

        // Collision scenario from a fresh reset: obj0 follows obj1 downward until obj1 lands on it
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        speed = 4'd4; button_d = 1'b1;
        repeat (7) do_tick();
        chk("coll_before", 32'(collision), 32'd0);
        do_tick();
        check_pos(0, 16, 267, "coll_obj0");
`ifdef COLLISION_EN
        chk("coll_set", 32'(collision), 32'd1);
        do_tick();
        check_pos(1, 20, 263, "coll_obj1_bounced");
`else
        chk("coll_tied", 32'(collision), 32'd0);
        do_tick();
        check_pos(1, 12, 271, "coll_obj1_free");
`endif
        button_d = 1'b0;
        pulse_c();
        chk("coll_clear", 32'(collision), 32'd0);

        // Reset in the middle of the update walk discards partial updates
        h_coord = 10'd639; v_coord = 10'd479;
        step();
        h_coord = 10'd700; v_coord = 10'd700;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_mode", 32'(mode), 32'd0);
        chk("midrst_coll", 32'(collision), 32'd0);
        check_pos(0, 16, 235, "midrst_obj0");
        check_pos(1, 48, 235, "midrst_obj1");
        check_pos(3, 112, 235, "midrst_obj3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
